// File: rtl/prog_clk_div.sv
// Programmable clock divider with a runtime-configurable period and high phase.
// A new config is held in a shadow register and becomes active only at a period boundary.
module prog_clk_div #(
  parameter int WIDTH        = 8,
  parameter int DEFAULT_DIV  = 10,
  parameter int DEFAULT_HIGH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] cfg_div,
  input  logic [WIDTH-1:0] cfg_high,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             div_clk,
  output logic             tick
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] n_act_q, n_act_d, h_act_q, h_act_d;
  logic [WIDTH-1:0] n_sh_q, n_sh_d, h_sh_q, h_sh_d;
  logic             pend_q, pend_d;
  logic             div_q, div_d;
  logic             tick_q, tick_d;
  logic             err_q, err_d;

  logic handshake, cfg_ok, wrap, apply;

  assign handshake = cfg_valid & ~pend_q;
  assign cfg_ok    = (cfg_div >= WIDTH'(2)) && (cfg_high >= WIDTH'(1)) && (cfg_high < cfg_div);
  assign wrap      = en & ~clr & (cnt_q == (n_act_q - WIDTH'(1)));
  // Handshakes need pending=0 and applying needs pending=1, so a request
  // accepted on a wrap cycle naturally waits for the following wrap.
  assign apply     = pend_q & (clr | wrap);

  always_comb begin
    cnt_d   = cnt_q;
    n_act_d = apply ? n_sh_q : n_act_q;
    h_act_d = apply ? h_sh_q : h_act_q;
    n_sh_d  = n_sh_q;
    h_sh_d  = h_sh_q;
    pend_d  = pend_q;
    tick_d  = 1'b0;
    err_d   = 1'b0;

    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      if (wrap) begin
        cnt_d  = '0;
        tick_d = 1'b1;
      end else begin
        cnt_d = cnt_q + WIDTH'(1);
      end
    end

    if (apply) begin
      pend_d = 1'b0;
    end

    if (handshake) begin
      if (cfg_ok) begin
        n_sh_d = cfg_div;
        h_sh_d = cfg_high;
        pend_d = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end

    // Registered compare against next-cycle state keeps div_clk aligned with cnt.
    div_d = (cnt_d >= (n_act_d - h_act_d));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      n_act_q <= WIDTH'(DEFAULT_DIV);
      h_act_q <= WIDTH'(DEFAULT_HIGH);
      n_sh_q  <= WIDTH'(DEFAULT_DIV);
      h_sh_q  <= WIDTH'(DEFAULT_HIGH);
      pend_q  <= 1'b0;
      div_q   <= 1'b0;
      tick_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      n_act_q <= n_act_d;
      h_act_q <= h_act_d;
      n_sh_q  <= n_sh_d;
      h_sh_q  <= h_sh_d;
      pend_q  <= pend_d;
      div_q   <= div_d;
      tick_q  <= tick_d;
      err_q   <= err_d;
    end
  end

  assign cfg_ready = ~pend_q;
  assign cfg_err   = err_q;
  assign div_clk   = div_q;
  assign tick      = tick_q;

endmodule

// File: tb/tb_prog_clk_div.sv
// Self-checking bench for prog_clk_div: directed scenarios plus random traffic,
// compared every cycle against an integer model of the divider's rules.
module tb_prog_clk_div;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       clr = 1'b0;
  logic [7:0] cfg_div = '0;
  logic [7:0] cfg_high = '0;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready, cfg_err, div_clk, tick;

  int passCnt = 0;
  int totalCnt = 0;

  // Reference model state
  int mN, mH, sN, sH, mCnt;
  bit mPend, mDiv, mTick, mErr;

  prog_clk_div #(.WIDTH(8), .DEFAULT_DIV(10), .DEFAULT_HIGH(5)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr),
    .cfg_div(cfg_div), .cfg_high(cfg_high), .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready), .cfg_err(cfg_err), .div_clk(div_clk), .tick(tick)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    mN = 10; mH = 5; sN = 10; sH = 5; mCnt = 0;
    mPend = 0; mDiv = 0; mTick = 0; mErr = 0;
  endtask

  task automatic model_edge();
    bit hs, ok;
    hs = cfg_valid && !mPend;
    ok = (cfg_div >= 2) && (cfg_high >= 1) && (cfg_high < cfg_div);
    mTick = 0;
    mErr = hs && !ok;
    if (clr) begin
      mCnt = 0;
      if (mPend) begin mN = sN; mH = sH; mPend = 0; end
    end else if (en) begin
      if (mCnt == mN - 1) begin
        mCnt = 0;
        mTick = 1;
        if (mPend) begin mN = sN; mH = sH; mPend = 0; end
      end else begin
        mCnt = mCnt + 1;
      end
    end
    if (hs && ok) begin sN = cfg_div; sH = cfg_high; mPend = 1; end
    mDiv = (mCnt >= mN - mH);
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
  endtask

  function automatic logic [3:0] expVec();
    return {mDiv, mTick, !mPend, mErr};
  endfunction

  task automatic run_to(int target);
    en = 1; clr = 0; cfg_valid = 0;
    for (int i = 0; i < 300 && mCnt != target; i++) step();
    totalCnt++;
    if (mCnt == target) passCnt++;
    else $display("[TB] FAIL run_to: model cnt %0d, wanted %0d", mCnt, target);
  endtask

  task automatic test_reset();
    logic [3:0] obs;
    rst_n = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    obs = {div_clk, tick, cfg_ready, cfg_err};
    totalCnt++;
    if (obs !== 4'b0010) $display("[TB] FAIL reset: got %b want 0010", obs);
    else passCnt++;
  endtask

  task automatic test_defaults();
    logic [3:0] obs;
    @(posedge clk); #1;
    rst_n = 1; en = 1;
    for (int i = 0; i < 25; i++) begin
      step();
      obs = {div_clk, tick, cfg_ready, cfg_err};
      totalCnt++;
      if (obs !== expVec()) $display("[TB] FAIL defaults cyc %0d: got %b want %b", i, obs, expVec());
      else passCnt++;
    end
  endtask

  task automatic test_freeze();
    logic [3:0] obs;
    run_to(7);
    en = 0;
    for (int i = 0; i < 8; i++) begin
      if (i == 5) en = 1;
      step();
      obs = {div_clk, tick, cfg_ready, cfg_err};
      totalCnt++;
      if (obs !== expVec()) $display("[TB] FAIL freeze cyc %0d: got %b want %b", i, obs, expVec());
      else passCnt++;
    end
  endtask

  task automatic test_reject();
    logic [3:0] obs;
    run_to(2);
    cfg_div = 8'd1; cfg_high = 8'd1; cfg_valid = 1;
    for (int i = 0; i < 14; i++) begin
      step();
      cfg_valid = 0;
      obs = {div_clk, tick, cfg_ready, cfg_err};
      totalCnt++;
      if (obs !== expVec()) $display("[TB] FAIL reject cyc %0d: got %b want %b", i, obs, expVec());
      else passCnt++;
    end
  endtask

  task automatic test_midload();
    logic [3:0] obs;
    run_to(3);
    cfg_div = 8'd4; cfg_high = 8'd1; cfg_valid = 1;
    for (int i = 0; i < 24; i++) begin
      step();
      cfg_valid = 0;
      obs = {div_clk, tick, cfg_ready, cfg_err};
      totalCnt++;
      if (obs !== expVec()) $display("[TB] FAIL midload cyc %0d: got %b want %b", i, obs, expVec());
      else passCnt++;
    end
  endtask

  task automatic test_clear();
    logic [3:0] obs;
    run_to(0);
    cfg_div = 8'd6; cfg_high = 8'd2; cfg_valid = 1;
    step();
    cfg_valid = 0;
    step();
    clr = 1;
    for (int i = 0; i < 16; i++) begin
      step();
      clr = 0;
      obs = {div_clk, tick, cfg_ready, cfg_err};
      totalCnt++;
      if (obs !== expVec()) $display("[TB] FAIL clear cyc %0d: got %b want %b", i, obs, expVec());
      else passCnt++;
    end
  endtask

  task automatic test_async_reset();
    logic [3:0] obs;
    en = 1; clr = 0; cfg_valid = 0;
    for (int i = 0; i < 50 && !mDiv; i++) step();
    totalCnt++;
    if (div_clk !== 1'b1) $display("[TB] FAIL async_pre_high: got %b want 1", div_clk);
    else passCnt++;
    #2 rst_n = 0;
    model_reset();
    #1;
    obs = {div_clk, tick, cfg_ready, cfg_err};
    totalCnt++;
    if (obs !== expVec()) $display("[TB] FAIL async_reset: got %b want %b", obs, expVec());
    else passCnt++;
    step();
    rst_n = 1;
    for (int i = 0; i < 12; i++) begin
      step();
      obs = {div_clk, tick, cfg_ready, cfg_err};
      totalCnt++;
      if (obs !== expVec()) $display("[TB] FAIL after_reset cyc %0d: got %b want %b", i, obs, expVec());
      else passCnt++;
    end
  endtask

  task automatic test_random();
    logic [3:0] obs;
    for (int i = 0; i < 400; i++) begin
      en        = ($urandom_range(0, 9) != 0);
      clr       = ($urandom_range(0, 24) == 0);
      cfg_valid = ($urandom_range(0, 4) == 0);
      cfg_div   = 8'($urandom_range(0, 12));
      cfg_high  = 8'($urandom_range(0, 12));
      step();
      obs = {div_clk, tick, cfg_ready, cfg_err};
      totalCnt++;
      if (obs !== expVec()) $display("[TB] FAIL random cyc %0d: got %b want %b", i, obs, expVec());
      else passCnt++;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    test_reset();
    test_defaults();
    test_freeze();
    test_reject();
    test_midload();
    test_clear();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
